vd_frame_arbiter: RTL and testbench
===================================

Name: vd_frame_arbiter

Overview:
- Round-robin scheduler that shares one Viterbi decoder block between N_REQ requesters.
- Grants one requester and captures its 16-bit coded word. Issues a one-cycle start plus the data to the decoder.
- Waits for the decoded 8-bit byte, or for a timeout. Returns the byte, tagged with an error flag, to the granted requester.
- Sits between the frame-source clients and the decoder; one transaction is in flight at a time.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IN_W, 16, coded word width (decoder input).
- OUT_W, 8, decoded byte width (decoder output).
- TIMEOUT_CYC, 64, maximum WAIT cycles before aborting the transaction.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_req  in  N_REQ  per-requester request level
- i_req_data  in  N_REQ*IN_W  per-requester coded word; slice k = [k*IN_W +: IN_W]
- o_gnt  out  N_REQ  one-hot grant, held LAUNCH..RESP
- o_rsp_valid  out  N_REQ  one-hot single-cycle response strobe
- o_rsp_data  out  OUT_W  decoded byte, valid with o_rsp_valid
- o_rsp_err  out  1  timeout flag, valid with o_rsp_valid
- o_busy  out  1  high in any state except IDLE
- o_vd_start  out  1  one-cycle start pulse to decoder
- o_vd_data  out  IN_W  coded word to decoder, held stable LAUNCH..RESP
- i_vd_data  in  OUT_W  decoder output byte
- i_vd_valid  in  1  decoder output strobe
- o_stray  out  1  single-cycle pulse: i_vd_valid seen outside WAIT

Behaviour:
- Reset (async, i_rst_n low):
  - All outputs 0; state IDLE; timeout counter 0.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction abandons it; no response is issued.
- Internal state is synchronous to i_clk.
- FSM states:
  - IDLE: if |i_req, pick winner w = first set bit searching from ptr+1 modulo N_REQ. Register w, latch slice w of i_req_data into o_vd_data, go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH (1 cycle): o_gnt[w]=1, o_vd_start=1, ptr<=w. Go to WAIT; timeout counter cleared.
  - WAIT: o_gnt[w]=1. If i_vd_valid, latch i_vd_data, err=0, go to RESP. Otherwise, if counter == TIMEOUT_CYC-1, data=0, err=1, go to RESP. Otherwise counter++.
  - RESP (1 cycle): o_gnt[w]=1, o_rsp_valid[w]=1, o_rsp_data and o_rsp_err driven. Go to IDLE.
- Latency:
  - Request seen in IDLE at cycle t → o_vd_start at t+1.
  - Decoder valid at cycle u (in WAIT) → o_rsp_valid at u+1.
  - Back-to-back grants: next LAUNCH no earlier than 2 cycles after RESP.
- Requester rules:
  - Hold i_req and its data until its o_rsp_valid.
  - Drop i_req in the cycle after the response, or it is re-queued. Fairness holds because the pointer has advanced.
  - Dropping i_req mid-transaction has no effect; the transaction completes and a response is still issued.
- Simultaneous events:
  - i_vd_valid in the same cycle the timeout expires: valid wins, err=0.
  - i_vd_valid in LAUNCH, RESP or IDLE is ignored for data and raises o_stray for 1 cycle.
- Counter width: $clog2(TIMEOUT_CYC)+1. No wrap is possible because the counter exits at TIMEOUT_CYC-1.
- Width rules: o_rsp_data zero-filled on timeout.
- Each of o_gnt and o_rsp_valid is one-hot or zero.

Decomposition:
- Package vd_arb_pkg:
  - state enum {IDLE, LAUNCH, WAIT, RESP} (2-bit).
  - Default widths IN_W_D=16, OUT_W_D=8, TIMEOUT_D=64.
- One sub-module, rr_pick:
  - Combinational; inputs req[N] and ptr; outputs one-hot and index of the winner.
  - Implemented as a double-width rotate-and-priority-encode.
- The FSM, counter and datapath registers stay in the top module.

Test Plan:
- Single request: i_req=4'b0001, data 16'hA5C3; decoder model answers 8'h5A after 10 cycles.
  - o_vd_start at t+1 with o_vd_data=A5C3.
  - o_rsp_valid=4'b0001 with data 5A, err 0, 11 cycles after LAUNCH.
- All 4 requesting continuously:
  - Grant order is 0,1,2,3,0.
  - Each o_rsp_valid matches its own requester's data; the minimum gap between successive LAUNCHes is held.
- Timeout: decoder never answers.
  - o_rsp_valid fires TIMEOUT_CYC+1 cycles after LAUNCH with data 00, err 1.
  - The next requester is then granted normally.
- Race and stray: i_vd_valid exactly at the timeout expiry cycle → err 0, decoder data returned. An extra i_vd_valid in IDLE → o_stray pulse, no rsp.
- Reset mid-WAIT: assert i_rst_n low.
  - All outputs 0 immediately; no response for that transaction.
  - After release, requester 0 wins first among {0,2}.
- Requester drops i_req during WAIT: response is still delivered to that index; the arbiter returns to IDLE.

Source files
------------

// File: rtl/vd_arb_pkg.sv
// vd_arb_pkg: shared state encoding and default widths for the Viterbi decoder arbiter.
package vd_arb_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} arb_state_e;
  localparam int IN_W_D    = 16;
  localparam int OUT_W_D   = 8;
  localparam int TIMEOUT_D = 64;
endpackage

// File: rtl/vd_frame_arbiter_rr_pick.sv
// rr_pick: round-robin winner select, searching upward from ptr+1 with wraparound.
module rr_pick #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             pos;
  // Rotating the doubled vector puts ptr+1 at bit 0, so the lowest set bit is the winner.
  always_comb begin
    dbl = {req, req} >> (int'(ptr) + 1);
    rot = dbl[N-1:0];
    pos = 0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) pos = i;
    any = |req;
    idx = PW'((int'(ptr) + 1 + pos) % N);
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/vd_frame_arbiter.sv
// vd_frame_arbiter: shares one Viterbi decoder among N_REQ requesters, one transaction at a time.
module vd_frame_arbiter
  import vd_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int IN_W        = IN_W_D,
  parameter int OUT_W       = OUT_W_D,
  parameter int TIMEOUT_CYC = TIMEOUT_D
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*IN_W-1:0]  i_req_data,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_rsp_valid,
  output logic [OUT_W-1:0]       o_rsp_data,
  output logic                   o_rsp_err,
  output logic                   o_busy,
  output logic                   o_vd_start,
  output logic [IN_W-1:0]        o_vd_data,
  input  logic [OUT_W-1:0]       i_vd_data,
  input  logic                   i_vd_valid,
  output logic                   o_stray
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  arb_state_e       state;
  logic [PW-1:0]    ptr, w, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_any;
  logic [CW-1:0]    cnt;
  rr_pick #(.N(N_REQ)) u_pick (
    .req(i_req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      ptr         <= PW'(N_REQ - 1);
      w           <= '0;
      cnt         <= '0;
      o_gnt       <= '0;
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
      o_vd_start  <= 1'b0;
      o_vd_data   <= '0;
      o_stray     <= 1'b0;
    end else begin
      o_vd_start  <= 1'b0;
      o_rsp_valid <= '0;
      o_stray     <= i_vd_valid && state != WAIT;
      case (state)
        IDLE: if (pick_any) begin
          w          <= pick_idx;
          o_gnt      <= pick_gnt;
          o_vd_data  <= i_req_data[int'(pick_idx)*IN_W +: IN_W];
          o_vd_start <= 1'b1;
          state      <= LAUNCH;
        end
        LAUNCH: begin
          ptr   <= w;
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (i_vd_valid) begin
          o_rsp_data  <= i_vd_data;
          o_rsp_err   <= 1'b0;
          o_rsp_valid <= o_gnt;
          state       <= RESP;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          o_rsp_data  <= '0;
          o_rsp_err   <= 1'b1;
          o_rsp_valid <= o_gnt;
          state       <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: begin
          o_gnt      <= '0;
          o_rsp_data <= '0;
          o_rsp_err  <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vd_frame_arbiter.sv
// tb_vd_frame_arbiter: directed scoreboard bench for the decoder arbiter.
module tb_vd_frame_arbiter;
  typedef struct {logic [3:0] gnt; logic [15:0] data; int gap;} launch_t;
  typedef struct {logic [3:0] gnt; logic [7:0] data; logic err; int lat;} rsp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] req_data = {16'h3C3C, 16'h9F21, 16'h4E17, 16'hA5C3};
  logic [7:0]  vd_data = '0;
  logic        vd_valid = 1'b0;
  logic [3:0]  o_gnt, o_rsp_valid;
  logic [7:0]  o_rsp_data;
  logic        o_rsp_err, o_busy, o_vd_start, o_stray;
  logic [15:0] o_vd_data;
  int total = 0, bad = 0, cyc = 0, last_launch = 0, launch_cyc = 0, n;
  launch_t lq[$];
  rsp_t    rq[$];
  launch_t le;
  rsp_t    re;
  vd_frame_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_data(req_data),
    .o_gnt(o_gnt), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_rsp_err(o_rsp_err), .o_busy(o_busy), .o_vd_start(o_vd_start),
    .o_vd_data(o_vd_data), .i_vd_data(vd_data), .i_vd_valid(vd_valid),
    .o_stray(o_stray)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] dw(input int k);
    return req_data[k*16 +: 16];
  endfunction
  task automatic push(input int k, input int gap, input logic [7:0] d, input logic e, input int lat);
    lq.push_back('{gnt: 4'(1 << k), data: dw(k), gap: gap});
    rq.push_back('{gnt: 4'(1 << k), data: d, err: e, lat: lat});
  endtask
  task automatic wait_start(output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!o_vd_start && cnt < 100);
    chk("start_seen", 32'(o_vd_start), 1);
  endtask
  task automatic wait_rsp();
    int c = 0;
    do begin @(negedge clk); c++; end while (o_rsp_valid == 0 && c < 200);
    chk("rsp_seen", 32'(|o_rsp_valid), 1);
  endtask
  task automatic answer(input int cycles, input logic [7:0] d);
    repeat (cycles) @(posedge clk);
    #1 vd_valid = 1'b1; vd_data = d;
    @(posedge clk); #1 vd_valid = 1'b0; vd_data = '0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  always @(negedge clk) if (rst_n === 1'b1) begin
    if (o_vd_start) begin
      if (lq.size() == 0) chk("launch_unexpected", 32'(o_vd_start), 0);
      else begin
        le = lq.pop_front();
        chk("launch_gnt", 32'(o_gnt), 32'(le.gnt));
        chk("launch_data", 32'(o_vd_data), 32'(le.data));
        if (le.gap != 0) chk("launch_gap", cyc - last_launch, le.gap);
      end
      last_launch = cyc;
      launch_cyc = cyc;
    end
    if (o_rsp_valid != 0) begin
      if (rq.size() == 0) chk("rsp_unexpected", 32'(o_rsp_valid), 0);
      else begin
        re = rq.pop_front();
        chk("rsp_valid", 32'(o_rsp_valid), 32'(re.gnt));
        chk("rsp_gnt", 32'(o_gnt), 32'(re.gnt));
        chk("rsp_data", 32'(o_rsp_data), 32'(re.data));
        chk("rsp_err", 32'(o_rsp_err), 32'(re.err));
        chk("rsp_latency", cyc - launch_cyc, re.lat);
      end
    end
  end
  initial begin
    #1 rst_n = 1'b0;
    #2 chk("reset_outs", {o_gnt, o_rsp_valid, o_rsp_data, o_rsp_err, o_busy, o_vd_start, o_stray}, 0);
    chk("reset_vd_data", 32'(o_vd_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // single request, decoder answers 10 cycles after launch
    @(posedge clk); #1 req = 4'b0001;
    push(0, 0, 8'h5A, 1'b0, 11);
    wait_start(n);
    chk("start_latency", n, 2);
    answer(10, 8'h5A);
    wait_rsp();
    @(posedge clk); #1 req = 4'b0000;
    repeat (2) @(posedge clk);
    // all four requesting: fresh pointer gives order 0,1,2,3,0
    #1 do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      push(i % 4, i == 0 ? 0 : 6, 8'h10 + 8'(i), 1'b0, 4);
      wait_start(n);
      answer(3, 8'h10 + 8'(i));
      wait_rsp();
    end
    @(posedge clk); #1 req = 4'b0000;
    repeat (2) @(posedge clk);
    // timeout on requester 1, then requester 2 served normally
    #1 req = 4'b0110;
    push(1, 0, 8'h00, 1'b1, 65);
    push(2, 67, 8'h77, 1'b0, 11);
    wait_start(n);
    wait_rsp();
    @(posedge clk); #1 req = 4'b0100;
    wait_start(n);
    answer(10, 8'h77);
    wait_rsp();
    @(posedge clk); #1 req = 4'b0000;
    // valid on the expiry cycle wins over the timeout
    @(posedge clk); #1 req = 4'b1000;
    push(3, 0, 8'hC7, 1'b0, 65);
    wait_start(n);
    answer(64, 8'hC7);
    wait_rsp();
    @(posedge clk); #1 req = 4'b0000;
    // stray decoder strobe while idle
    @(posedge clk); #1 vd_valid = 1'b1; vd_data = 8'hEE;
    @(negedge clk) chk("stray_before", 32'(o_stray), 0);
    chk("idle_busy", 32'(o_busy), 0);
    @(posedge clk); #1 vd_valid = 1'b0; vd_data = '0;
    @(negedge clk) chk("stray_pulse", 32'(o_stray), 1);
    @(negedge clk) chk("stray_after", 32'(o_stray), 0);
    // reset mid-WAIT after requester 0 took the grant
    @(posedge clk); #1 req = 4'b0101;
    lq.push_back('{gnt: 4'b0001, data: dw(0), gap: 0});
    wait_start(n);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("midwait_reset_outs", {o_gnt, o_rsp_valid, o_rsp_data, o_rsp_err, o_busy, o_vd_start, o_stray}, 0);
    chk("midwait_reset_vd_data", 32'(o_vd_data), 0);
    push(0, 0, 8'h3C, 1'b0, 11);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_start(n);
    answer(10, 8'h3C);
    wait_rsp();
    // requester 2 drops its request during WAIT and still gets its response
    push(2, 13, 8'h99, 1'b0, 11);
    @(posedge clk); #1 req = 4'b0100;
    wait_start(n);
    @(posedge clk); #1 req = 4'b0000;
    answer(9, 8'h99);
    wait_rsp();
    @(negedge clk) chk("final_busy", 32'(o_busy), 0);
    repeat (3) @(negedge clk);
    chk("launch_queue_empty", lq.size(), 0);
    chk("rsp_queue_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
